// File: rtl/spi_ram_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module  : spi_ram_ctrl_if                                                  |
// | Brief   : Frame/read-data bundle between an SPI slave and spi_ram_ctrl.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       busy;

  // master: the SPI slave that produces frames and shifts read data out
  modport master (output din, rx_valid, input dout, tx_valid, busy);
  modport slave  (input din, rx_valid, output dout, tx_valid, busy);
endinterface

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : spi_ram_ctrl                                                     |
// | Brief   : Command-driven single-port RAM behind an SPI slave; 10-bit frames |
// |           carry set-wr-addr / write / set-rd-addr / read commands.         |
// |           Optional macro RAM_AUTOINC_EN: post-increment addresses on       |
// |           write and read.                                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_HOLD   = 8
) (
  input  wire             clk,
  input  wire             rst_n,
  spi_ram_ctrl_if.slave   bus
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(TX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_TX_IDLE = 1'b0,
    ST_TX_HOLD = 1'b1
  } tx_state_t;

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [7:0]           r_dout;
  logic [7:0]           r_mem [MEM_DEPTH];

  logic w_cmd_set_wa;
  logic w_cmd_write;
  logic w_cmd_set_ra;
  logic w_cmd_read;

  assign w_cmd_set_wa = bus.rx_valid && (bus.din[9:8] == 2'b00);
  assign w_cmd_write  = bus.rx_valid && (bus.din[9:8] == 2'b01);
  assign w_cmd_set_ra = bus.rx_valid && (bus.din[9:8] == 2'b10);
  assign w_cmd_read   = bus.rx_valid && (bus.din[9:8] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_TX_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A read always (re)starts the hold window, even mid-hold
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_cmd_read) begin
      w_state_nxt = ST_TX_HOLD;
      w_cnt_nxt   = c_cnt_load;
    end else begin
      case (r_state)
        ST_TX_HOLD: begin
          if (r_cnt == '0) w_state_nxt = ST_TX_IDLE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_dout    <= '0;
    end else begin
      if (w_cmd_set_wa) r_wr_addr <= bus.din[ADDR_SIZE-1:0];
      if (w_cmd_set_ra) r_rd_addr <= bus.din[ADDR_SIZE-1:0];
      if (w_cmd_read)   r_dout    <= r_mem[r_rd_addr];
`ifdef RAM_AUTOINC_EN
      if (w_cmd_write)  r_wr_addr <= r_wr_addr + 1'b1;
      if (w_cmd_read)   r_rd_addr <= r_rd_addr + 1'b1;
`endif
    end
  end

  // Storage is deliberately unreset so it maps onto a plain RAM macro
  always_ff @(posedge clk) begin
    if (w_cmd_write) r_mem[r_wr_addr] <= bus.din[7:0];
  end

  assign bus.dout     = r_dout;
  assign bus.tx_valid = (r_state == ST_TX_HOLD);
  assign bus.busy     = (r_state == ST_TX_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_ram_ctrl                                                  |
// | Brief   : Directed self-checking bench for spi_ram_ctrl (8-bit and 4-bit   |
// |           address instances). Honours RAM_AUTOINC_EN when defined.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_ram_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  spi_ram_ctrl_if bus8 ();
  spi_ram_ctrl_if bus4 ();

  spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256), .TX_HOLD(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  spi_ram_ctrl #(.ADDR_SIZE(4), .MEM_DEPTH(16), .TX_HOLD(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one frame for one rising edge; returns 1 ns after that edge
  task automatic send8(input logic [9:0] f, input logic vld);
    bus8.din      = f;
    bus8.rx_valid = vld;
    @(posedge clk);
    #1;
    bus8.rx_valid = 1'b0;
  endtask

  task automatic send4(input logic [9:0] f);
    bus4.din      = f;
    bus4.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (bus8.tx_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: tx_valid=%b busy=%b dout=%h, need 0 0 00",
               bus8.tx_valid, bus8.busy, bus8.dout);
    end
  endtask

  task automatic test_basic_read;
    send8(10'h005, 1'b1);
    send8(10'h1A5, 1'b1);
    send8(10'h205, 1'b1);
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'hA5) begin
      n_err++;
      $display("FAIL basic_dout: got %h need A5", bus8.dout);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus8.tx_valid !== 1'b1) begin
        n_err++;
        $display("FAIL basic_txvalid_cycle%0d: got %b need 1", i, bus8.tx_valid);
      end
      if (i == 3) begin
        n_cmp++;
        if (bus8.busy !== 1'b1) begin
          n_err++;
          $display("FAIL basic_busy_mid: got %b need 1", bus8.busy);
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus8.tx_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.dout !== 8'hA5) begin
      n_err++;
      $display("FAIL basic_end: tx_valid=%b busy=%b dout=%h, need 0 0 A5",
               bus8.tx_valid, bus8.busy, bus8.dout);
    end
  endtask

  task automatic test_hold_retrigger;
    send8(10'h205, 1'b1);
    send8(10'h300, 1'b1);
    send8(10'h006, 1'b1);
    send8(10'h13C, 1'b1);
    send8(10'h206, 1'b1);
    n_cmp++;
    if (bus8.tx_valid !== 1'b1 || bus8.dout !== 8'hA5) begin
      n_err++;
      $display("FAIL retrig_mid_hold: tx_valid=%b dout=%h, need 1 A5",
               bus8.tx_valid, bus8.dout);
    end
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h3C) begin
      n_err++;
      $display("FAIL retrig_dout: got %h need 3C", bus8.dout);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus8.tx_valid !== 1'b1) begin
        n_err++;
        $display("FAIL retrig_txvalid_cycle%0d: got %b need 1", i, bus8.tx_valid);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus8.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL retrig_end: tx_valid=%b need 0", bus8.tx_valid);
    end
  endtask

  task automatic test_rx_invalid;
    send8(10'h006, 1'b1);
    send8(10'h206, 1'b1);
    send8(10'h1FF, 1'b0);
    send8(10'h0FF, 1'b0);
    send8(10'h2FF, 1'b0);
    send8(10'h3FF, 1'b0);
    n_cmp++;
    if (bus8.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_no_tx: tx_valid=%b need 0", bus8.tx_valid);
    end
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h3C) begin
      n_err++;
      $display("FAIL invalid_mem_kept: dout=%h need 3C", bus8.dout);
    end
  endtask

`ifdef RAM_AUTOINC_EN
  task automatic test_autoinc;
    send8(10'h0FF, 1'b1);
    send8(10'h111, 1'b1);
    send8(10'h122, 1'b1);
    send8(10'h2FF, 1'b1);
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h11) begin
      n_err++;
      $display("FAIL autoinc_rd_ff: dout=%h need 11", bus8.dout);
    end
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h22) begin
      n_err++;
      $display("FAIL autoinc_rd_wrap: dout=%h need 22", bus8.dout);
    end
  endtask
`else
  task automatic test_fixed_addr;
    send8(10'h010, 1'b1);
    send8(10'h111, 1'b1);
    send8(10'h122, 1'b1);
    send8(10'h210, 1'b1);
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h22) begin
      n_err++;
      $display("FAIL fixed_overwrite: dout=%h need 22", bus8.dout);
    end
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h22) begin
      n_err++;
      $display("FAIL fixed_reread: dout=%h need 22", bus8.dout);
    end
  endtask
`endif

  task automatic test_addr_size4;
    send4(10'h0F3);
    send4(10'h177);
    send4(10'h0E5);
    send4(10'h199);
    send4(10'h2F3);
    send4(10'h300);
    n_cmp++;
    if (bus4.dout !== 8'h77 || bus4.tx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL a4_addr3: dout=%h tx_valid=%b need 77 1", bus4.dout, bus4.tx_valid);
    end
    send4(10'h2A5);
    send4(10'h300);
    n_cmp++;
    if (bus4.dout !== 8'h99) begin
      n_err++;
      $display("FAIL a4_addr5: dout=%h need 99", bus4.dout);
    end
  endtask

  task automatic test_reset_mid_hold;
    send8(10'h000, 1'b1);
    send8(10'h15A, 1'b1);
    send8(10'h205, 1'b1);
    send8(10'h300, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus8.tx_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_hold: tx_valid=%b busy=%b dout=%h, need 0 0 00",
               bus8.tx_valid, bus8.busy, bus8.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus8.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stays_idle: tx_valid=%b need 0", bus8.tx_valid);
    end
    send8(10'h300, 1'b1);
    n_cmp++;
    if (bus8.dout !== 8'h5A || bus8.tx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rdaddr_zero: dout=%h tx_valid=%b need 5A 1",
               bus8.dout, bus8.tx_valid);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus8.din      = '0;
    bus8.rx_valid = 1'b0;
    bus4.din      = '0;
    bus4.rx_valid = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic_read();
    test_hold_retrigger();
    test_rx_invalid();
`ifdef RAM_AUTOINC_EN
    test_autoinc();
`else
    test_fixed_addr();
`endif
    test_addr_size4();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
